// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flex
// Purpose  : Single-clock ready/valid FIFO, any depth >= 1, optional
//            fall-through, fill level, almost-full/empty flags, sync flush.
// Revision : 1.0
// ============================================================================
module sync_fifo_flex #(
  parameter type T               = logic,
  parameter int  DEPTH           = 8,
  parameter bit  FALL_THROUGH    = 1'b0,
  parameter int  ALMOST_FULL_TH  = DEPTH - 1,
  parameter int  ALMOST_EMPTY_TH = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  T                             src_data_i,
  input  logic                         src_valid_i,
  output logic                         src_ready_o,
  output T                             dst_data_o,
  output logic                         dst_valid_o,
  input  logic                         dst_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o
);

  localparam int AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW  = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_chk_depth
    $fatal(1, "sync_fifo_flex: DEPTH must be >= 1");
  end
  if (ALMOST_FULL_TH > DEPTH) begin : g_chk_af
    $fatal(1, "sync_fifo_flex: ALMOST_FULL_TH exceeds DEPTH");
  end
  if (ALMOST_EMPTY_TH > DEPTH) begin : g_chk_ae
    $fatal(1, "sync_fifo_flex: ALMOST_EMPTY_TH exceeds DEPTH");
  end

  T                 mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic gate, full, empty, bypass, push, pop, wr_en, rd_adv;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  always_comb begin
    gate   = !flush_i && !rst_i;
    full   = (cnt_q == CntW'(DEPTH));
    empty  = (cnt_q == '0);
    bypass = FALL_THROUGH && empty;

    src_ready_o = !full && gate;
    if (bypass) begin
      dst_valid_o = src_valid_i && gate;
      dst_data_o  = src_data_i;
    end else begin
      dst_valid_o = !empty && gate;
      dst_data_o  = mem_q[rptr_q];
    end

    push   = src_valid_i && src_ready_o;
    pop    = dst_valid_o && dst_ready_i;
    // A bypassed item never touches storage; a pop while bypassing implies a push.
    wr_en  = push && !(bypass && pop);
    rd_adv = pop && !bypass;

    wptr_d = wr_en  ? next_ptr(wptr_q) : wptr_q;
    rptr_d = rd_adv ? next_ptr(rptr_q) : rptr_q;
    unique case ({wr_en, rd_adv})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= src_data_i;
    end
  end

  assign usage_o        = cnt_q;
  assign almost_full_o  = (cnt_q >= CntW'(ALMOST_FULL_TH));
  assign almost_empty_o = (cnt_q <= CntW'(ALMOST_EMPTY_TH));

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_flex
// Purpose  : Self-checking bench for sync_fifo_flex (depth 8, depth 5, fall-through).
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = '0;
  logic       dst_ready = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: DEPTH 8 normal; 1: DEPTH 5 normal; 2: DEPTH 8 fall-through.
  logic       a_srdy, a_dval, a_af, a_ae;
  logic [7:0] a_dout;
  logic [3:0] a_use;
  logic       b_srdy, b_dval, b_af, b_ae;
  logic [7:0] b_dout;
  logic [2:0] b_use;
  logic       c_srdy, c_dval, c_af, c_ae;
  logic [7:0] c_dout;
  logic [3:0] c_use;

  sync_fifo_flex #(.T(logic [7:0]), .DEPTH(8), .FALL_THROUGH(1'b0)) u_d8 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(a_srdy),
    .dst_data_o(a_dout), .dst_valid_o(a_dval), .dst_ready_i(dst_ready),
    .usage_o(a_use), .almost_full_o(a_af), .almost_empty_o(a_ae));

  sync_fifo_flex #(.T(logic [7:0]), .DEPTH(5), .FALL_THROUGH(1'b0),
                   .ALMOST_FULL_TH(5), .ALMOST_EMPTY_TH(2)) u_d5 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(b_srdy),
    .dst_data_o(b_dout), .dst_valid_o(b_dval), .dst_ready_i(dst_ready),
    .usage_o(b_use), .almost_full_o(b_af), .almost_empty_o(b_ae));

  sync_fifo_flex #(.T(logic [7:0]), .DEPTH(8), .FALL_THROUGH(1'b1)) u_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(c_srdy),
    .dst_data_o(c_dout), .dst_valid_o(c_dval), .dst_ready_i(dst_ready),
    .usage_o(c_use), .almost_full_o(c_af), .almost_empty_o(c_ae));

  int         cur = 0;
  logic       s_srdy, s_dval, s_af, s_ae;
  logic [7:0] s_dout;
  logic [3:0] s_use;

  always_comb begin
    s_srdy = a_srdy; s_dval = a_dval; s_af = a_af; s_ae = a_ae;
    s_dout = a_dout; s_use = a_use;
    case (cur)
      1: begin
        s_srdy = b_srdy; s_dval = b_dval; s_af = b_af; s_ae = b_ae;
        s_dout = b_dout; s_use = {1'b0, b_use};
      end
      2: begin
        s_srdy = c_srdy; s_dval = c_dval; s_af = c_af; s_ae = c_ae;
        s_dout = c_dout; s_use = c_use;
      end
      default: ;
    endcase
  end

  int dep   [3] = '{8, 5, 8};
  int ftm   [3] = '{0, 0, 1};
  int af_th [3] = '{7, 5, 7};
  int ae_th [3] = '{1, 2, 1};

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb [$];
  int         mcnt = 0;
  int         n_push = 0;
  int         n_pop = 0;
  logic       pre_srdy, pre_dval;
  logic [7:0] pre_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // One clock cycle: drive inputs at the negedge, check combinational
  // outputs against the model, then check registered state after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic fl);
    logic gate, bypass, e_rdy, e_val, push, pop;
    logic [7:0] e_d;
    src_valid = v; src_data = d; dst_ready = r; flush = fl;
    #1;
    gate   = !fl && !rst;
    bypass = (ftm[cur] != 0) && (mcnt == 0);
    e_rdy  = (mcnt != dep[cur]) && gate;
    e_val  = bypass ? (v && gate) : ((mcnt != 0) && gate);
    e_d    = bypass ? d : ((sb.size() > 0) ? sb[0] : 8'h00);
    pre_srdy = s_srdy; pre_dval = s_dval; pre_dout = s_dout;
    chk("src_ready", {31'd0, s_srdy}, {31'd0, e_rdy});
    chk("dst_valid", {31'd0, s_dval}, {31'd0, e_val});
    if (e_val) chk("dst_data", {24'd0, s_dout}, {24'd0, e_d});
    push = v && e_rdy;
    pop  = e_val && r;
    @(posedge clk);
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (push) n_push++;
      if (pop)  n_pop++;
      if (!(bypass && push && pop)) begin
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(d);
      end
    end
    mcnt = sb.size();
    @(negedge clk);
    chk("usage", {28'd0, s_use}, 32'(mcnt));
    chk("almost_full", {31'd0, s_af}, {31'd0, mcnt >= af_th[cur]});
    chk("almost_empty", {31'd0, s_ae}, {31'd0, mcnt <= ae_th[cur]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("oor_usage", {28'd0, s_use}, 32'd0);
    chk("oor_af", {31'd0, s_af}, {31'd0, af_th[cur] == 0});
    chk("oor_ae", {31'd0, s_ae}, 32'd1);
    chk("oor_srdy", {31'd0, s_srdy}, 32'd1);
    chk("oor_dval", {31'd0, s_dval}, 32'd0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e_srdy;
    logic       e_dval;
    logic [7:0] e_dout;
    logic [3:0] e_use;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                              input logic es, input logic ev, input logic [7:0] ed,
                              input int eu);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.e_srdy = es; t.e_dval = ev; t.e_dout = ed;
    t.e_use = 4'(eu); t.e_af = (eu >= 7); t.e_ae = (eu <= 1);
    return t;
  endfunction

  vec_t tbl [17];

  initial begin
    // Fill 0x11..0x88, refuse a ninth push while full, then drain in order.
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1, i != 0, 8'h11, i + 1);
    tbl[8] = mk(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 8'h11, 8);
    for (int k = 0; k < 8; k++)
      tbl[9 + k] = mk(1'b0, 8'h00, 1'b1, k != 0, 1'b1, 8'(8'h11 * (k + 1)), 7 - k);

    @(negedge clk);

    // Test 1
    cur = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      chk("t1_srdy", {31'd0, pre_srdy}, {31'd0, tbl[i].e_srdy});
      chk("t1_dval", {31'd0, pre_dval}, {31'd0, tbl[i].e_dval});
      if (tbl[i].e_dval) chk("t1_dout", {24'd0, pre_dout}, {24'd0, tbl[i].e_dout});
      chk("t1_usage", {28'd0, s_use}, {28'd0, tbl[i].e_use});
      chk("t1_af", {31'd0, s_af}, {31'd0, tbl[i].e_af});
      chk("t1_ae", {31'd0, s_ae}, {31'd0, tbl[i].e_ae});
    end
    chk("t1_empty_dval", {31'd0, s_dval}, 32'd0);

    // Test 2: non-power-of-two depth, random handshakes, 23 items
    cur = 1;
    do_reset();
    n_push = 0; n_pop = 0;
    for (int c = 0; c < 600 && n_pop < 23; c++) begin
      cycle((n_push < 23) && ($urandom_range(0, 3) != 0), 8'(8'h30 + n_push),
            $urandom_range(0, 2) != 0, 1'b0);
      chk("t2_usage_le5", {31'd0, s_use <= 4'd5}, 32'd1);
    end
    chk("t2_all_popped", 32'(n_pop), 32'd23);

    // Test 3: fall-through
    cur = 2;
    do_reset();
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("t3_dval", {31'd0, pre_dval}, 32'd1);
    chk("t3_dout", {24'd0, pre_dout}, 32'hA5);
    chk("t3_usage", {28'd0, s_use}, 32'd0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t3_store_usage", {28'd0, s_use}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_stored_dout", {24'd0, pre_dout}, 32'h5A);

    // Test 4: push+pop when full, and at usage 3
    cur = 0;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("t4_full_srdy", {31'd0, pre_srdy}, 32'd0);
    chk("t4_full_usage", {28'd0, s_use}, 32'd7);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hF0, 1'b1, 1'b0);
    chk("t4_mid_usage", {28'd0, s_use}, 32'd3);
    for (int i = 0; i < 10 && sb.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_drained", {28'd0, s_use}, 32'd0);

    // Test 5: flush beats a simultaneous push and pop
    cur = 0;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    chk("t5_flush_srdy", {31'd0, pre_srdy}, 32'd0);
    chk("t5_flush_dval", {31'd0, pre_dval}, 32'd0);
    chk("t5_flush_usage", {28'd0, s_use}, 32'd0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    chk("t5_post_dval", {31'd0, pre_dval}, 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_next_dout", {24'd0, pre_dout}, 32'h42);

    // Test 6: reset mid-stream
    cur = 0;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t6_rst_srdy", {31'd0, pre_srdy}, 32'd0);
    chk("t6_rst_dval", {31'd0, pre_dval}, 32'd0);
    chk("t6_rst_usage", {28'd0, s_use}, 32'd0);
    chk("t6_rst_ae", {31'd0, s_ae}, 32'd1);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
